// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- fetch sequencer for the 5-stage pipeline.
//
// Owns the fetch PC and runs a single-outstanding request/acknowledge
// handshake to instruction memory. Memory latency, hazard stalls and taken
// branches from EX are turned into bubbles (hold) and flushes. Exactly one
// valid instruction is presented per accepted fetch.
//
// Optional feature: define FETCH_PERF_EN to add two saturating performance
// counters (perf_fetched, perf_bubbles). With the macro undefined the ports
// and counters are absent and behaviour is otherwise identical.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  [31:0] word-aligned fetch address
//   imem_ack     in   imem_rdata valid for the current request
//   imem_rdata   in   [31:0] fetched instruction word
//   stall        in   hazard unit: IF/ID cannot accept this cycle
//   redirect     in   taken branch/jump from EX
//   redirect_pc  in   [31:0] redirect target (bits [1:0] forced to 0)
//   pc           out  [31:0] PC of delivered instruction, 0 when none
//   instruction  out  [31:0] delivered instruction, NOP when none
//   fetch_valid  out  pc/instruction carry a real instruction
//   flush        out  kill IF stage contents
//   hold         out  insert bubble in IF
//   perf_fetched out  [31:0] delivered-instruction count (FETCH_PERF_EN)
//   perf_bubbles out  [31:0] bubble-cycle count (FETCH_PERF_EN)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] instruction,
   output logic        fetch_valid,
   output logic        flush,
`ifdef FETCH_PERF_EN
   output logic        hold,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`else
   output logic        hold
`endif
);

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_ADDR = RESET_PC & WORD_MASK;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;   // address of the request being drained
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;

   logic [31:0] target_pc;
   logic        deliver;

   assign target_pc = redirect_pc & WORD_MASK;

   // -------------------------------------------------------------------------
   // Next-state and same-cycle output decode
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      buf_pc_d     = buf_pc_q;
      buf_instr_d  = buf_instr_q;
      deliver      = 1'b0;
      pc           = 32'h0000_0000;
      instruction  = NOP_INSTR;

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            if (redirect) begin
               // Redirect wins over ack and stall; any returned data is dropped.
               fetch_pc_d = target_pc;
               if (!imem_ack) begin
                  drain_addr_d = fetch_pc_q;
                  state_d      = DRAIN;
               end
            end else if (imem_ack) begin
               if (stall) begin
                  buf_pc_d    = fetch_pc_q;
                  buf_instr_d = imem_rdata;
                  state_d     = HOLD;
               end else begin
                  deliver     = 1'b1;
                  pc          = fetch_pc_q;
                  instruction = imem_rdata;
                  fetch_pc_d  = fetch_pc_q + 32'd4;
               end
            end
         end

         HOLD: begin
            if (redirect) begin
               fetch_pc_d = target_pc;
               state_d    = REQ;
            end else begin
               pc          = buf_pc_q;
               instruction = buf_instr_q;
               if (!stall) begin
                  deliver    = 1'b1;
                  fetch_pc_d = buf_pc_q + 32'd4;
                  state_d    = REQ;
               end
            end
         end

         DRAIN: begin
            if (redirect) begin
               fetch_pc_d = target_pc;
            end
            // The draining ack retires the only outstanding request, so leave
            // even when a newer redirect lands in the same cycle: the target
            // is already in fetch_pc and nothing else is in flight to wait for.
            if (imem_ack) begin
               state_d = REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
   assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
   assign fetch_valid = deliver;
   assign flush       = redirect && (state_q != IDLE);
   assign hold        = !deliver && !flush;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_ADDR;
         drain_addr_q <= RESET_ADDR;
         buf_pc_q     <= 32'h0000_0000;
         buf_instr_q  <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         buf_pc_q     <= buf_pc_d;
         buf_instr_q  <= buf_instr_d;
      end
   end

`ifdef FETCH_PERF_EN
   // -------------------------------------------------------------------------
   // Saturating performance counters
   // -------------------------------------------------------------------------
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_bubbles_q, perf_bubbles_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (fetch_valid && (perf_fetched_q != 32'hFFFF_FFFF)) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      if (hold && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
         perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= 32'h0000_0000;
         perf_bubbles_q <= 32'h0000_0000;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- directed testbench for fetch_ctrl.
//
// Two instances share clock, reset and inputs: dut (RESET_PC = 0) and dut_w
// (RESET_PC = 32'hFFFF_FFFC, for the address wrap). Inputs are driven on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge. Each row of a scenario table gives the inputs for one cycle and
// the hand-computed expected outputs
// {imem_req, imem_addr, fetch_valid, flush, hold, pc, instruction}.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        imem_req,  w_imem_req;
   logic [31:0] imem_addr, w_imem_addr;
   logic [31:0] pc,        w_pc;
   logic [31:0] instruction, w_instruction;
   logic        fetch_valid, w_fetch_valid;
   logic        flush,     w_flush;
   logic        hold,      w_hold;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_bubbles, w_perf_fetched, w_perf_bubbles;
`endif

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      logic [99:0] exp;
   } row_t;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .instruction (instruction),
      .fetch_valid (fetch_valid),
      .flush       (flush),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched),
      .perf_bubbles(perf_bubbles),
`endif
      .hold        (hold)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (w_imem_req),
      .imem_addr   (w_imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (w_pc),
      .instruction (w_instruction),
      .fetch_valid (w_fetch_valid),
      .flush       (w_flush),
`ifdef FETCH_PERF_EN
      .perf_fetched(w_perf_fetched),
      .perf_bubbles(w_perf_bubbles),
`endif
      .hold        (w_hold)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [99:0] pack(input logic req, input logic [31:0] addr,
                                        input logic fv, input logic fl, input logic hd,
                                        input logic [31:0] p, input logic [31:0] ins);
      return {req, addr, fv, fl, hd, p, ins};
   endfunction

   function automatic logic [99:0] obs();
      return {imem_req, imem_addr, fetch_valid, flush, hold, pc, instruction};
   endfunction

   // Drive one cycle's inputs on the falling edge, then settle.
   task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                        input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      imem_ack    = ack;
      imem_rdata  = rdata;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
   endtask

   // Pulse reset between edges; returns with both DUTs in IDLE, so the next
   // drive() cycle sees them in REQ at their reset PC.
   task automatic reset_dut();
      @(negedge clk);
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      rst         = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [99:0] exp;
      rst = 1'b1;
      imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      @(negedge clk); #1;
      exp = pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, NOP);
      total++;
      if (obs() !== exp) $display("FAIL reset_values got %h expected %h", obs(), exp);
      else passed++;
      total++;
      if (w_imem_addr !== 32'hFFFF_FFFC) $display("FAIL reset_addr_w got %h expected fffffffc", w_imem_addr);
      else passed++;
      // Released mid-cycle: still IDLE until the next rising edge.
      rst = 1'b0;
      #1;
      total++;
      if (obs() !== exp) $display("FAIL idle_after_release got %h expected %h", obs(), exp);
      else passed++;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      exp = pack(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, NOP);
      total++;
      if (obs() !== exp) $display("FAIL first_req got %h expected %h", obs(), exp);
      else passed++;
   endtask

   task automatic test_zero_wait();
      logic [99:0] exp;
      logic [31:0] a, d, wa;
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         a = 32'(k * 4);
         d = 32'hA000_0000 + 32'(k);
         drive(1'b1, d, 1'b0, 1'b0, 32'h0);
         exp = pack(1'b1, a, 1'b1, 1'b0, 1'b0, a, d);
         total++;
         if (obs() !== exp) $display("FAIL zero_wait[%0d] got %h expected %h", k, obs(), exp);
         else passed++;
         if (k < 3) begin
            wa = 32'hFFFF_FFFC + 32'(k * 4);
            total++;
            if ({w_imem_addr, w_pc, w_fetch_valid} !== {wa, wa, 1'b1})
               $display("FAIL wrap[%0d] got addr %h pc %h fv %b expected %h %h 1",
                        k, w_imem_addr, w_pc, w_fetch_valid, wa, wa);
            else passed++;
         end
      end
   endtask

   task automatic test_wait_states();
      logic [99:0] exp;
      logic [31:0] a, d;
      logic        ack;
      reset_dut();
      for (int j = 0; j < 6; j++) begin
         ack = (j % 3 == 2);
         a   = 32'((j / 3) * 4);
         d   = 32'hB000_0000 + 32'(j);
         drive(ack, d, 1'b0, 1'b0, 32'h0);
         exp = ack ? pack(1'b1, a, 1'b1, 1'b0, 1'b0, a, d)
                   : pack(1'b1, a, 1'b0, 1'b0, 1'b1, 32'h0, NOP);
         total++;
         if (obs() !== exp) $display("FAIL wait_states[%0d] got %h expected %h", j, obs(), exp);
         else passed++;
      end
   endtask

   task automatic test_stall();
      row_t rows[7];
      rows[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0, pack(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h11)};
      rows[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 32'h0, pack(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd4, 32'h22)};
      rows[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 32'h0, pack(1'b1, 32'd8, 1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      rows[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, pack(1'b0, 32'd8, 1'b0, 1'b0, 1'b1, 32'd8, 32'h33)};
      rows[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, pack(1'b0, 32'd8, 1'b0, 1'b0, 1'b1, 32'd8, 32'h33)};
      rows[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, pack(1'b0, 32'd8, 1'b1, 1'b0, 1'b0, 32'd8, 32'h33)};
      rows[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, pack(1'b1, 32'd12, 1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      reset_dut();
      foreach (rows[i]) begin
         drive(rows[i].ack, rows[i].rdata, rows[i].st, rows[i].rd, rows[i].rpc);
         total++;
         if (obs() !== rows[i].exp) $display("FAIL stall[%0d] got %h expected %h", i, obs(), rows[i].exp);
         else passed++;
      end
   endtask

   task automatic test_redirect_drain();
      row_t rows[7];
      rows[0] = '{1'b1, 32'h11,   1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0, 32'h11)};
      rows[1] = '{1'b1, 32'h22,   1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd4,   1'b1, 1'b0, 1'b0, 32'd4, 32'h22)};
      rows[2] = '{1'b1, 32'h33,   1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd8,   1'b1, 1'b0, 1'b0, 32'd8, 32'h33)};
      rows[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h100, pack(1'b1, 32'd12,  1'b0, 1'b1, 1'b0, 32'd0, NOP)};
      rows[4] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd12,  1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      rows[5] = '{1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd12,  1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      rows[6] = '{1'b1, 32'h44,   1'b0, 1'b0, 32'h0,   pack(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44)};
      reset_dut();
      foreach (rows[i]) begin
         drive(rows[i].ack, rows[i].rdata, rows[i].st, rows[i].rd, rows[i].rpc);
         total++;
         if (obs() !== rows[i].exp) $display("FAIL redirect_drain[%0d] got %h expected %h", i, obs(), rows[i].exp);
         else passed++;
      end
   endtask

   task automatic test_redirect_priority();
      row_t rows[9];
      // Redirect + stall + ack together, unaligned target.
      rows[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0,   pack(1'b1, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0, 32'h11)};
      rows[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 32'h203, pack(1'b1, 32'd4,   1'b0, 1'b1, 1'b0, 32'd0, NOP)};
      // Into HOLD at 0x200, then redirect out of HOLD.
      rows[2] = '{1'b1, 32'h55, 1'b1, 1'b0, 32'h0,   pack(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      rows[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h302, pack(1'b0, 32'h200, 1'b0, 1'b1, 1'b0, 32'd0, NOP)};
      rows[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   pack(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      // Redirect into DRAIN, then a second redirect overwrites the target.
      rows[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h400, pack(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'd0, NOP)};
      rows[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h500, pack(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'd0, NOP)};
      rows[7] = '{1'b1, 32'h66, 1'b0, 1'b0, 32'h0,   pack(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'd0, NOP)};
      rows[8] = '{1'b1, 32'h77, 1'b0, 1'b0, 32'h0,   pack(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h500, 32'h77)};
      reset_dut();
      foreach (rows[i]) begin
         drive(rows[i].ack, rows[i].rdata, rows[i].st, rows[i].rd, rows[i].rpc);
         total++;
         if (obs() !== rows[i].exp) $display("FAIL redirect_priority[%0d] got %h expected %h", i, obs(), rows[i].exp);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic [99:0] exp;
      reset_dut();
      drive(1'b1, 32'h11, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 32'h22, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 32'h0,  1'b1, 1'b0, 32'h0);
      exp = pack(1'b0, 32'd4, 1'b0, 1'b0, 1'b1, 32'd4, 32'h22);
      total++;
      if (obs() !== exp) $display("FAIL async_pre_hold got %h expected %h", obs(), exp);
      else passed++;
      // Assert reset between clock edges: outputs must change with no edge.
      #1;
      rst      = 1'b1;
      imem_ack = 1'b0;
      #1;
      exp = pack(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, NOP);
      total++;
      if (obs() !== exp) $display("FAIL async_reset got %h expected %h", obs(), exp);
      else passed++;
      total++;
      if (w_imem_addr !== 32'hFFFF_FFFC) $display("FAIL async_reset_w got %h expected fffffffc", w_imem_addr);
      else passed++;
      @(negedge clk);
      rst   = 1'b0;
      stall = 1'b0;
      drive(1'b1, 32'h88, 1'b0, 1'b0, 32'h0);
      exp = pack(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h88);
      total++;
      if (obs() !== exp) $display("FAIL restart_after_reset got %h expected %h", obs(), exp);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_redirect_drain();
      test_redirect_priority();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
